// File: rtl/ddr2_arb_pkg.sv
// Shared types and default widths for the DDR2 local-interface arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package ddr2_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int PORT_W    = 1;
    localparam int NUM_PORTS = 2;

    localparam int ADDR_W_DEF    = 22;
    localparam int DATA_W_DEF    = 128;
    localparam int BE_W_DEF      = 16;
    localparam int TAG_DEPTH_DEF = 8;
    localparam int WDATA_LAT_DEF = 1;

    typedef logic [PORT_W-1:0] port_id_t;

endpackage

// File: rtl/ddr2_arb_tag_fifo.sv
// Ordered FIFO of owner IDs for outstanding controller commands.
// Latency: head visible the cycle after push; pop is combinational-read, registered-advance.
// Backpressure: push ignored when full, pop ignored when empty (caller masks both).
module ddr2_arb_tag_fifo
    import ddr2_arb_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_vld,
    input  port_id_t         push_dat,
    input  logic             pop_vld,
    output port_id_t         head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    // Pointers wrap naturally, so DEPTH must be a power of 2 and at least 2.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    port_id_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ddr2_local_arbiter.sv
// Round-robin 2-port arbiter onto one DDR2 controller local interface, routing returns by tag.
// Latency: 1 cycle IDLE->GRANT, command presented in GRANT; one command per 2 cycles minimum.
// Backpressure: port ready follows local_ready in GRANT; ports masked while their tag FIFO is full.
module ddr2_local_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BE_W      = BE_W_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF,
    parameter int WDATA_LAT = WDATA_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              p0_read_req,
    input  logic              p0_write_req,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic              p0_autopch_req,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [BE_W-1:0]   p0_be,
    output logic              p0_ready,
    output logic              p0_wdata_req,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rdata_valid,

    input  logic              p1_read_req,
    input  logic              p1_write_req,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic              p1_autopch_req,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [BE_W-1:0]   p1_be,
    output logic              p1_ready,
    output logic              p1_wdata_req,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rdata_valid,

    input  logic              local_init_done,
    input  logic              local_ready,
    input  logic              local_wdata_req,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic              local_burstbegin,
    output logic [ADDR_W-1:0] local_address,
    output logic              local_autopch_req,
    output logic              local_size,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    output logic              arb_error
);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    arb_state_t           state;
    arb_state_t           state_nxt;
    port_id_t             g;
    port_id_t             g_nxt;
    port_id_t             lw;
    port_id_t             lw_nxt;
    logic [NUM_PORTS-1:0] elig;

    logic                 rd_full;
    logic                 rd_empty;
    logic [CNT_W-1:0]     rd_count;
    port_id_t             rd_head;
    logic                 wr_full;
    logic                 wr_empty;
    logic [CNT_W-1:0]     wr_count;
    port_id_t             wr_head;

    logic                 sel_rd;
    logic                 sel_wr;
    logic                 sel_apch;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 in_grant;
    logic                 cmd_vld;
    logic                 accept;
    logic                 rd_push;
    logic                 wr_push;
    logic                 rd_pop;
    logic                 wr_pop;
    logic                 wd_vld;
    port_id_t             wd_own;

    // Eligibility masks each request type by its own FIFO, so a push can never overflow.
    assign elig[0] = (p0_read_req && !rd_full) || (p0_write_req && !wr_full);
    assign elig[1] = (p1_read_req && !rd_full) || (p1_write_req && !wr_full);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            g     <= '0;
            lw    <= port_id_t'(1);
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            lw    <= lw_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        lw_nxt    = lw;
        case (state)
            IDLE: begin
                if (local_init_done && (|elig)) begin
                    state_nxt = GRANT;
                    if (&elig) g_nxt = ~lw;
                    else       g_nxt = elig[1] ? port_id_t'(1) : port_id_t'(0);
                end
            end
            GRANT: begin
                if (accept) begin
                    state_nxt = IDLE;
                    lw_nxt    = g;
                end else if (!cmd_vld) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_rd   = g[0] ? p1_read_req    : p0_read_req;
    assign sel_wr   = g[0] ? p1_write_req   : p0_write_req;
    assign sel_apch = g[0] ? p1_autopch_req : p0_autopch_req;
    assign sel_addr = g[0] ? p1_address     : p0_address;

    // A port driving both requests gets its read issued; the write waits for a later grant.
    assign in_grant          = (state == GRANT);
    assign local_read_req    = in_grant && sel_rd && !rd_full;
    assign local_write_req   = in_grant && !sel_rd && sel_wr && !wr_full;
    assign cmd_vld           = local_read_req || local_write_req;
    assign accept            = cmd_vld && local_ready;
    assign local_burstbegin  = cmd_vld;
    assign local_address     = in_grant ? sel_addr : '0;
    assign local_autopch_req = in_grant && sel_apch;
    assign local_size        = 1'b1;

    assign p0_ready = accept && !g[0];
    assign p1_ready = accept && g[0];

    assign rd_push = accept && local_read_req;
    assign wr_push = accept && local_write_req;
    assign rd_pop  = local_rdata_valid && !rd_empty;
    assign wr_pop  = local_wdata_req && !wr_empty;

    ddr2_arb_tag_fifo #(.DEPTH(TAG_DEPTH), .CNT_W(CNT_W)) u_rd_tags (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (rd_push),
        .push_dat (g),
        .pop_vld  (rd_pop),
        .head_dat (rd_head),
        .full     (rd_full),
        .empty    (rd_empty),
        .count    (rd_count)
    );

    ddr2_arb_tag_fifo #(.DEPTH(TAG_DEPTH), .CNT_W(CNT_W)) u_wr_tags (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (wr_push),
        .push_dat (g),
        .pop_vld  (wr_pop),
        .head_dat (wr_head),
        .full     (wr_full),
        .empty    (wr_empty),
        .count    (wr_count)
    );

    assign p0_rdata       = local_rdata;
    assign p1_rdata       = local_rdata;
    assign p0_rdata_valid = rd_pop && !rd_head[0];
    assign p1_rdata_valid = rd_pop && rd_head[0];
    assign p0_wdata_req   = wr_pop && !wr_head[0];
    assign p1_wdata_req   = wr_pop && wr_head[0];

    // The write-data mux owner trails the beat request by the controller's wdata latency.
    generate
        if (WDATA_LAT == 0) begin : g_wd_lat0
            assign wd_vld = wr_pop;
            assign wd_own = wr_head;
        end else begin : g_wd_lat1
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wd_vld <= 1'b0;
                    wd_own <= '0;
                end else begin
                    wd_vld <= wr_pop;
                    wd_own <= wr_head;
                end
            end
        end
    endgenerate

    assign local_wdata = !wd_vld ? '0 : (wd_own[0] ? p1_wdata : p0_wdata);
    assign local_be    = !wd_vld ? '0 : (wd_own[0] ? p1_be    : p0_be);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_error <= 1'b0;
        end else if ((local_rdata_valid && rd_empty) || (local_wdata_req && wr_empty)) begin
            arb_error <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (rd_count <= CNT_W'(TAG_DEPTH));
            assert (wr_count <= CNT_W'(TAG_DEPTH));
            assert (!(rd_push && rd_full));
            assert (!(wr_push && wr_full));
        end
    end

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// Self-checking bench for ddr2_local_arbiter: command vector table plus tag-routing scoreboards.
module tb_ddr2_local_arbiter;
    localparam int ADDR_W    = 22;
    localparam int DATA_W    = 128;
    localparam int BE_W      = 16;
    localparam int TAG_DEPTH = 8;
    localparam int WDATA_LAT = 1;

    localparam logic [DATA_W-1:0] P0_WD = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [DATA_W-1:0] P1_WD = 128'hFEDC_BA98_7654_3210_8899_AABB_CCDD_EEFF;
    localparam logic [BE_W-1:0]   P0_BE = 16'h00FF;
    localparam logic [BE_W-1:0]   P1_BE = 16'hF00F;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              p0_read_req, p0_write_req, p0_autopch_req;
    logic [ADDR_W-1:0] p0_address;
    logic [DATA_W-1:0] p0_wdata;
    logic [BE_W-1:0]   p0_be;
    logic              p0_ready, p0_wdata_req, p0_rdata_valid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_read_req, p1_write_req, p1_autopch_req;
    logic [ADDR_W-1:0] p1_address;
    logic [DATA_W-1:0] p1_wdata;
    logic [BE_W-1:0]   p1_be;
    logic              p1_ready, p1_wdata_req, p1_rdata_valid;
    logic [DATA_W-1:0] p1_rdata;
    logic              local_init_done, local_ready, local_wdata_req, local_rdata_valid;
    logic [DATA_W-1:0] local_rdata;
    logic              local_read_req, local_write_req, local_burstbegin;
    logic [ADDR_W-1:0] local_address;
    logic              local_autopch_req, local_size;
    logic [DATA_W-1:0] local_wdata;
    logic [BE_W-1:0]   local_be;
    logic              arb_error;

    always #5 clk = ~clk;

    ddr2_local_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .TAG_DEPTH(TAG_DEPTH), .WDATA_LAT(WDATA_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_read_req(p0_read_req), .p0_write_req(p0_write_req), .p0_address(p0_address),
        .p0_autopch_req(p0_autopch_req), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_ready(p0_ready), .p0_wdata_req(p0_wdata_req), .p0_rdata(p0_rdata),
        .p0_rdata_valid(p0_rdata_valid),
        .p1_read_req(p1_read_req), .p1_write_req(p1_write_req), .p1_address(p1_address),
        .p1_autopch_req(p1_autopch_req), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_ready(p1_ready), .p1_wdata_req(p1_wdata_req), .p1_rdata(p1_rdata),
        .p1_rdata_valid(p1_rdata_valid),
        .local_init_done(local_init_done), .local_ready(local_ready),
        .local_wdata_req(local_wdata_req), .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid),
        .local_read_req(local_read_req), .local_write_req(local_write_req),
        .local_burstbegin(local_burstbegin), .local_address(local_address),
        .local_autopch_req(local_autopch_req), .local_size(local_size),
        .local_wdata(local_wdata), .local_be(local_be), .arb_error(arb_error)
    );

    typedef struct {
        logic              p0_rd;
        logic              p0_wr;
        logic              p1_rd;
        logic              p1_wr;
        logic [ADDR_W-1:0] a0;
        logic [ADDR_W-1:0] a1;
        int                exp_port;
        logic              exp_rd;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int rd_sb[$];
    int wr_sb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        p0_read_req = 0; p0_write_req = 0; p1_read_req = 0; p1_write_req = 0;
        local_wdata_req = 0; local_rdata_valid = 0; local_rdata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_accept(input string tag, input int exp_port, input logic exp_rd,
                               input logic [ADDR_W-1:0] exp_addr);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((local_read_req || local_write_req) && local_ready) begin
                got = 1;
                chk({tag, " p0_ready"}, p0_ready, exp_port == 0);
                chk({tag, " p1_ready"}, p1_ready, exp_port == 1);
                chk({tag, " read_req"}, local_read_req, exp_rd);
                chk({tag, " write_req"}, local_write_req, !exp_rd);
                chk({tag, " address"}, local_address, exp_addr);
                chk({tag, " autopch"}, local_autopch_req, exp_port == 1);
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s accept timeout: got none required port %0d", tag, exp_port);
        end
    endtask

    task automatic rd_return(input logic [DATA_W-1:0] d);
        int exp;
        @(posedge clk); #1;
        local_rdata_valid = 1; local_rdata = d;
        @(negedge clk);
        if (rd_sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd scoreboard empty: got return required none");
        end else begin
            exp = rd_sb.pop_front();
            chk("rd p0_rdata_valid", p0_rdata_valid, exp == 0);
            chk("rd p1_rdata_valid", p1_rdata_valid, exp == 1);
            chk("rd data", (exp == 1) ? p1_rdata : p0_rdata, d);
        end
        @(posedge clk); #1;
        local_rdata_valid = 0;
    endtask

    task automatic wr_return();
        int exp;
        @(posedge clk); #1;
        local_wdata_req = 1;
        @(negedge clk);
        if (wr_sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL wr scoreboard empty: got beat request required none");
            exp = 0;
        end else begin
            exp = wr_sb.pop_front();
            chk("wr p0_wdata_req", p0_wdata_req, exp == 0);
            chk("wr p1_wdata_req", p1_wdata_req, exp == 1);
        end
        @(posedge clk); #1;
        local_wdata_req = 0;
        @(negedge clk);
        chk("wr local_wdata", local_wdata, (exp == 1) ? P1_WD : P0_WD);
        chk("wr local_be", local_be, (exp == 1) ? P1_BE : P0_BE);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        // lw starts at 1, so ties go to the port that did not win last.
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 22'h000010, 22'h0, 0, 1'b0, 22'h000010};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 22'h0, 22'h000020, 1, 1'b1, 22'h000020};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 22'h000030, 22'h000040, 0, 1'b1, 22'h000030};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 22'h000050, 22'h000060, 1, 1'b1, 22'h000060};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 22'h000070, 22'h0, 0, 1'b1, 22'h000070};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 22'h000080, 22'h000090, 1, 1'b0, 22'h000090};

        p0_address = '0; p1_address = '0;
        p0_autopch_req = 0; p1_autopch_req = 1;
        p0_wdata = P0_WD; p1_wdata = P1_WD; p0_be = P0_BE; p1_be = P1_BE;
        local_init_done = 0; local_ready = 1;
        do_reset();

        @(negedge clk);
        chk("reset local_read_req", local_read_req, 0);
        chk("reset local_write_req", local_write_req, 0);
        chk("reset local_burstbegin", local_burstbegin, 0);
        chk("reset local_size", local_size, 1);
        chk("reset local_address", local_address, 0);
        chk("reset p0_ready", p0_ready, 0);
        chk("reset p1_ready", p1_ready, 0);
        chk("reset local_wdata", local_wdata, 0);
        chk("reset local_be", local_be, 0);
        chk("reset arb_error", arb_error, 0);

        // Requests pending before calibration completes must not reach the controller.
        @(posedge clk); #1;
        p0_address = 22'h000100; p1_address = 22'h000200;
        p0_read_req = 1; p1_read_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("pre-init cmd", local_read_req | local_write_req, 0);
        end
        @(posedge clk); #1;
        local_init_done = 1;
        for (int k = 0; k < 4; k++) begin
            rd_sb.push_back(k % 2);
            wait_accept($sformatf("cont rd %0d", k), k % 2, 1'b1,
                        (k % 2) ? 22'h000200 : 22'h000100);
        end
        @(posedge clk); #1;
        p0_read_req = 0; p1_read_req = 0;
        rd_return(128'hD0D0_0000_0000_0000_0000_0000_0000_0001);

        // Async reset while a read is presented and three reads are outstanding.
        @(posedge clk); #1;
        local_ready = 0; p0_read_req = 1;
        repeat (2) @(negedge clk);
        chk("held grant read_req", local_read_req, 1);
        #1 reset_n = 0;
        #1;
        chk("async rst read_req", local_read_req, 0);
        chk("async rst burstbegin", local_burstbegin, 0);
        chk("async rst address", local_address, 0);
        rd_sb.delete();
        p0_read_req = 0; local_ready = 1;
        #1 reset_n = 1;

        @(posedge clk); #1;
        local_rdata_valid = 1; local_rdata = 128'hBAD;
        @(negedge clk);
        chk("underflow p0_rdata_valid", p0_rdata_valid, 0);
        chk("underflow p1_rdata_valid", p1_rdata_valid, 0);
        @(posedge clk); #1;
        local_rdata_valid = 0;
        @(negedge clk);
        chk("underflow arb_error", arb_error, 1);
        @(posedge clk); #1;
        local_wdata_req = 1;
        @(negedge clk);
        chk("wr underflow p0_wdata_req", p0_wdata_req, 0);
        chk("wr underflow p1_wdata_req", p1_wdata_req, 0);
        @(posedge clk); #1;
        local_wdata_req = 0;
        @(negedge clk);
        chk("wr underflow local_wdata", local_wdata, 0);
        chk("wr underflow local_be", local_be, 0);
        repeat (3) @(negedge clk);
        chk("arb_error sticky", arb_error, 1);
        do_reset();
        @(negedge clk);
        chk("arb_error cleared", arb_error, 0);

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            p0_read_req = tbl[i].p0_rd; p0_write_req = tbl[i].p0_wr;
            p1_read_req = tbl[i].p1_rd; p1_write_req = tbl[i].p1_wr;
            p0_address = tbl[i].a0; p1_address = tbl[i].a1;
            if (tbl[i].exp_rd) rd_sb.push_back(tbl[i].exp_port);
            else               wr_sb.push_back(tbl[i].exp_port);
            wait_accept($sformatf("vec%0d", i), tbl[i].exp_port, tbl[i].exp_rd, tbl[i].exp_addr);
            @(posedge clk); #1;
            p0_read_req = 0; p0_write_req = 0; p1_read_req = 0; p1_write_req = 0;
        end
        wr_return();
        wr_return();
        for (int i = 0; i < 4; i++)
            rd_return(128'hA000 + 128'(i));

        // Fill the read tag FIFO from port 1; a port 0 write must still get through.
        @(posedge clk); #1;
        p1_address = 22'h000300; p1_read_req = 1;
        for (int k = 0; k < TAG_DEPTH; k++) begin
            rd_sb.push_back(1);
            wait_accept($sformatf("fill rd %0d", k), 1, 1'b1, 22'h000300);
        end
        @(posedge clk); #1;
        p0_address = 22'h000123; p0_write_req = 1;
        wr_sb.push_back(0);
        wait_accept("write while rd full", 0, 1'b0, 22'h000123);
        @(posedge clk); #1;
        p0_write_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd full p1_ready", p1_ready, 0);
            chk("rd full read_req", local_read_req, 0);
        end
        rd_return(128'hB000);
        rd_sb.push_back(1);
        wait_accept("rd after slot freed", 1, 1'b1, 22'h000300);
        @(posedge clk); #1;
        p1_read_req = 0;
        wr_return();
        for (int i = 0; i < TAG_DEPTH; i++)
            rd_return(128'hC000 + 128'(i));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
